aemb2_iwbif: RTL and testbench

Instruction-side Wishbone master and miss handler for the AEMB2 core; sits directly upstream of the instruction cache. Each cycle it selects the cache lookup address. On a cache miss it stalls fetch, reads the missing instruction(s) over the instruction Wishbone bus, and drives the cache fill strobe and address so returned words are written into the cache. Once the fill is done, it releases the stall.

---
 rtl/aemb2_iwbif_if.sv | 30 +++
 rtl/aemb2_iwbif.sv | 132 +++++++++++++
 tb/tb_aemb2_iwbif.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/aemb2_iwbif_if.sv
// Instruction-side Wishbone bus bundle for the AEMB2 fetch path.
// The master modport belongs to aemb2_iwbif; the slave modport belongs to the memory/arbiter side.
interface aemb2_iwbif_if #(
    parameter int AEMB_IWB = 32
);
    logic [AEMB_IWB-1:2] iwb_adr_o;
    logic                iwb_stb_o;
    logic                iwb_cyc_o;
    logic [3:0]          iwb_sel_o;
    logic                iwb_wre_o;
    logic                iwb_ack_i;

    modport master (
        output iwb_adr_o,
        output iwb_stb_o,
        output iwb_cyc_o,
        output iwb_sel_o,
        output iwb_wre_o,
        input  iwb_ack_i
    );

    modport slave (
        input  iwb_adr_o,
        input  iwb_stb_o,
        input  iwb_cyc_o,
        input  iwb_sel_o,
        input  iwb_wre_o,
        output iwb_ack_i
    );
endinterface

// File: rtl/aemb2_iwbif.sv
// AEMB2 instruction Wishbone master and I-cache miss handler (INIT/IDLE/FILL/SETL).
// Define AEMB2_IWB_BURST_EN to fill 2^AEMB_ILW words per miss, critical word first.
module aemb2_iwbif #(
    parameter int AEMB_IWB = 32,
    parameter int AEMB_ILW = 2
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic [AEMB_IWB-1:2] ich_nxt,
    input  logic [AEMB_IWB-1:2] rpc_if,
    input  logic                ich_hit,
    aemb2_iwbif_if.master       iwb,
    output logic [AEMB_IWB-1:2] ich_adr,
    output logic                ich_fil,
    output logic                ich_stl
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_FILL = 2'd2,
        ST_SETL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AEMB_IWB-1:2] adr_q, adr_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                fil_q, fil_d;
    logic                last_word;
    logic [AEMB_IWB-1:2] miss_adr;

`ifdef AEMB2_IWB_BURST_EN
    // Burst fill: the miss address is kept separately because adr_q wraps through the block.
    logic [AEMB_ILW-1:0] cnt_q, cnt_d;
    logic [AEMB_IWB-1:2] miss_q, miss_d;
    logic [AEMB_IWB-1:2] adr_wrap;

    always_comb begin
        adr_wrap = adr_q;
        adr_wrap[AEMB_ILW+1:2] = adr_q[AEMB_ILW+1:2] + AEMB_ILW'(1);
    end

    assign last_word = &cnt_q;
    assign miss_adr  = miss_q;

    always_ff @(posedge gclk) begin
        cnt_q  <= cnt_d;
        miss_q <= miss_d;
    end
`else
    // Single-word fill: adr_q never moves during FILL, so it doubles as the miss address.
    assign last_word = 1'b1;
    assign miss_adr  = adr_q;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
`ifdef AEMB2_IWB_BURST_EN
        cnt_d   = cnt_q;
        miss_d  = miss_q;
`endif
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (!ich_hit) begin
                    state_d = ST_FILL;
                    adr_d   = rpc_if;
`ifdef AEMB2_IWB_BURST_EN
                    cnt_d   = '0;
                    miss_d  = rpc_if;
`endif
                end
            end
            ST_FILL: begin
                if (iwb.iwb_ack_i) begin
                    if (last_word) begin
                        state_d = ST_SETL;
                    end else begin
`ifdef AEMB2_IWB_BURST_EN
                        adr_d = adr_wrap;
                        cnt_d = cnt_q + AEMB_ILW'(1);
`endif
                    end
                end
            end
            ST_SETL: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase

        // Bus controls are registered and simply mirror "next state is FILL".
        cyc_d = (state_d == ST_FILL);
        stb_d = (state_d == ST_FILL);
        fil_d = (state_d == ST_FILL);
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= ST_INIT;
            adr_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            fil_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            fil_q   <= fil_d;
        end
    end

    // SETL points the cache back at the miss word so the following IDLE cycle sees a hit.
    always_comb begin
        ich_adr = ich_nxt;
        case (state_q)
            ST_FILL: ich_adr = adr_q;
            ST_SETL: ich_adr = miss_adr;
            default: ich_adr = ich_nxt;
        endcase
    end

    assign ich_stl       = (state_q != ST_IDLE) | ~ich_hit;
    assign ich_fil       = fil_q;
    assign iwb.iwb_adr_o = adr_q;
    assign iwb.iwb_cyc_o = cyc_q;
    assign iwb.iwb_stb_o = stb_q;
    assign iwb.iwb_sel_o = 4'hF;
    assign iwb.iwb_wre_o = 1'b0;

endmodule

// File: tb/tb_aemb2_iwbif.sv
// Directed bench for aemb2_iwbif; burst-fill steps run only when AEMB2_IWB_BURST_EN is defined.
module tb_aemb2_iwbif;

    localparam int AW = 32;

    logic          gclk;
    logic          grst;
    logic [AW-1:2] ich_nxt;
    logic [AW-1:2] rpc_if;
    logic          ich_hit;
    logic [AW-1:2] ich_adr;
    logic          ich_fil;
    logic          ich_stl;

    int n_assert;
    int n_fail;

    aemb2_iwbif_if #(.AEMB_IWB(AW)) iwb ();

    aemb2_iwbif #(.AEMB_IWB(AW), .AEMB_ILW(2)) dut (
        .gclk    (gclk),
        .grst    (grst),
        .ich_nxt (ich_nxt),
        .rpc_if  (rpc_if),
        .ich_hit (ich_hit),
        .iwb     (iwb.master),
        .ich_adr (ich_adr),
        .ich_fil (ich_fil),
        .ich_stl (ich_stl)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just past the next rising edge; inputs are changed here, checks follow a settle delay.
    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        grst     = 1'b1;
        ich_hit  = 1'b0;
        ich_nxt  = '0;
        rpc_if   = '0;
        iwb.iwb_ack_i = 1'b0;

        tick();
        tick();
        #1;
        chk("rst_cyc", 32'(iwb.iwb_cyc_o), 32'd0);
        chk("rst_stb", 32'(iwb.iwb_stb_o), 32'd0);
        chk("rst_fil", 32'(ich_fil), 32'd0);
        chk("rst_adr", 32'(iwb.iwb_adr_o), 32'd0);
        chk("rst_stl", 32'(ich_stl), 32'd1);
        chk("rst_sel", 32'(iwb.iwb_sel_o), 32'hF);
        chk("rst_wre", 32'(iwb.iwb_wre_o), 32'd0);

        // INIT cycle: a miss indication here must be ignored
        grst = 1'b0;
        ich_hit = 1'b0;
        tick();
        chk("init_ignore_stb", 32'(iwb.iwb_stb_o), 32'd0);

        // Steady hit
        ich_hit = 1'b1; ich_nxt = 30'h100; rpc_if = 30'h0FF;
        #1;
        chk("hit_adr0", 32'(ich_adr), 32'h100);
        chk("hit_stl0", 32'(ich_stl), 32'd0);
        tick();
        ich_nxt = 30'h101; rpc_if = 30'h100;
        iwb.iwb_ack_i = 1'b1;
        #1;
        chk("hit_adr1", 32'(ich_adr), 32'h101);
        chk("hit_stl1", 32'(ich_stl), 32'd0);
        chk("hit_stb1", 32'(iwb.iwb_stb_o), 32'd0);
        tick();
        // Stray ack in IDLE had no effect
        iwb.iwb_ack_i = 1'b0;
        #1;
        chk("stray_fil", 32'(ich_fil), 32'd0);
        chk("stray_stb", 32'(iwb.iwb_stb_o), 32'd0);
        chk("stray_stl", 32'(ich_stl), 32'd0);

`ifndef AEMB2_IWB_BURST_EN
        // Single miss at 0x040, ack three cycles after stb
        ich_hit = 1'b0; rpc_if = 30'h040; ich_nxt = 30'h040;
        #1;
        chk("miss_stl_comb", 32'(ich_stl), 32'd1);
        tick();
        chk("miss_stb", 32'(iwb.iwb_stb_o), 32'd1);
        chk("miss_cyc", 32'(iwb.iwb_cyc_o), 32'd1);
        chk("miss_fil", 32'(ich_fil), 32'd1);
        chk("miss_adr", 32'(iwb.iwb_adr_o), 32'h040);
        chk("miss_ich_adr", 32'(ich_adr), 32'h040);
        tick();
        chk("miss_hold2", 32'(iwb.iwb_stb_o), 32'd1);
        tick();
        chk("miss_hold3", 32'(iwb.iwb_stb_o), 32'd1);
        tick();
        iwb.iwb_ack_i = 1'b1;
        #1;
        chk("miss_stb_at_ack", 32'(iwb.iwb_stb_o), 32'd1);
        tick();
        iwb.iwb_ack_i = 1'b0;
        ich_nxt = 30'h041;
        #1;
        chk("setl_stb", 32'(iwb.iwb_stb_o), 32'd0);
        chk("setl_fil", 32'(ich_fil), 32'd0);
        chk("setl_cyc", 32'(iwb.iwb_cyc_o), 32'd0);
        chk("setl_ich_adr", 32'(ich_adr), 32'h040);
        chk("setl_stl", 32'(ich_stl), 32'd1);
        tick();
        ich_hit = 1'b1;
        #1;
        chk("post_fill_stl", 32'(ich_stl), 32'd0);
        chk("post_fill_adr", 32'(ich_adr), 32'h041);

        // Back-to-back misses at 0x010 then 0x200
        ich_hit = 1'b0; rpc_if = 30'h010; ich_nxt = 30'h010;
        tick();
        chk("b2b_adr1", 32'(iwb.iwb_adr_o), 32'h010);
        chk("b2b_stb1", 32'(iwb.iwb_stb_o), 32'd1);
        iwb.iwb_ack_i = 1'b1;
        tick();
        iwb.iwb_ack_i = 1'b0;
        #1;
        chk("b2b_setl_stb", 32'(iwb.iwb_stb_o), 32'd0);
        chk("b2b_setl_adr", 32'(ich_adr), 32'h010);
        tick();
        rpc_if = 30'h200; ich_nxt = 30'h200; ich_hit = 1'b0;
        #1;
        chk("b2b_idle_stb", 32'(iwb.iwb_stb_o), 32'd0);
        chk("b2b_idle_stl", 32'(ich_stl), 32'd1);
        tick();
        chk("b2b_stb2", 32'(iwb.iwb_stb_o), 32'd1);
        chk("b2b_adr2", 32'(iwb.iwb_adr_o), 32'h200);
        iwb.iwb_ack_i = 1'b1;
        tick();
        iwb.iwb_ack_i = 1'b0;
        ich_nxt = 30'h201;
        #1;
        chk("b2b_setl2_adr", 32'(ich_adr), 32'h200);
        chk("b2b_setl2_stb", 32'(iwb.iwb_stb_o), 32'd0);
        tick();
        ich_hit = 1'b1;
        #1;
        chk("b2b_done_stl", 32'(ich_stl), 32'd0);
`else
        // Burst miss at 0x046, ack every cycle: critical word first, wrap in block of 4
        ich_hit = 1'b0; rpc_if = 30'h046; ich_nxt = 30'h046;
        tick();
        chk("bst_adr0", 32'(iwb.iwb_adr_o), 32'h046);
        chk("bst_stb0", 32'(iwb.iwb_stb_o), 32'd1);
        iwb.iwb_ack_i = 1'b1;
        tick();
        chk("bst_adr1", 32'(iwb.iwb_adr_o), 32'h047);
        chk("bst_ich_adr1", 32'(ich_adr), 32'h047);
        tick();
        chk("bst_adr2", 32'(iwb.iwb_adr_o), 32'h044);
        chk("bst_stb2", 32'(iwb.iwb_stb_o), 32'd1);
        tick();
        chk("bst_adr3", 32'(iwb.iwb_adr_o), 32'h045);
        chk("bst_fil3", 32'(ich_fil), 32'd1);
        tick();
        iwb.iwb_ack_i = 1'b0;
        ich_nxt = 30'h047;
        #1;
        chk("bst_setl_stb", 32'(iwb.iwb_stb_o), 32'd0);
        chk("bst_setl_fil", 32'(ich_fil), 32'd0);
        chk("bst_setl_adr", 32'(ich_adr), 32'h046);
        tick();
        ich_hit = 1'b1;
        #1;
        chk("bst_done_stl", 32'(ich_stl), 32'd0);
`endif

        // Reset during the second FILL cycle, then a late ack
        ich_hit = 1'b0; rpc_if = 30'h080; ich_nxt = 30'h080;
        tick();
        chk("rmf_stb_fill", 32'(iwb.iwb_stb_o), 32'd1);
        tick();
        grst = 1'b1;
        tick();
        grst = 1'b0;
        iwb.iwb_ack_i = 1'b1;
        ich_hit = 1'b1;
        #1;
        chk("rmf_cyc", 32'(iwb.iwb_cyc_o), 32'd0);
        chk("rmf_stb", 32'(iwb.iwb_stb_o), 32'd0);
        chk("rmf_fil", 32'(ich_fil), 32'd0);
        chk("rmf_stl_init", 32'(ich_stl), 32'd1);
        tick();
        iwb.iwb_ack_i = 1'b0;
        #1;
        chk("rmf_late_fil", 32'(ich_fil), 32'd0);
        chk("rmf_late_stb", 32'(iwb.iwb_stb_o), 32'd0);
        chk("rmf_idle_stl", 32'(ich_stl), 32'd0);
        tick();
        chk("rmf_still_idle", 32'(ich_stl), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
